fir_sequencer: RTL and testbench

- Control FSM that paces the FIR datapath at a fixed sample rate.
- Each sample period it requests the next sample from the sample ROM with a one-cycle LDX pulse and captures the 16-bit sample. It writes the sample into a circular delay-line RAM, then steps the external MAC through all taps, one tap per cycle, using delay-line and coefficient addresses.
- Flags the filtered result valid and tracks position in the 200-sample test sequence.

---
 rtl/fir_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fir_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// Sample-rate control FSM for the FIR datapath: fetch, delay-line write, N_TAPS MAC steps, flush, result strobe.
// Define FIR_SEQ_OVR_CNT_EN to add the saturating OVR_CNT dropped-tick counter.
module fir_sequencer #(
  parameter int N_TAPS     = 16,
  parameter int AW         = 4,
  parameter int SAMPLE_DIV = 64,
  parameter int MAC_LAT    = 2,
  parameter int ROM_DEPTH  = 200,
  parameter int DW         = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  output logic          LDX,
  input  logic [DW-1:0] X_IN,
  output logic          DL_WE,
  output logic [AW-1:0] DL_WADDR,
  output logic [DW-1:0] DL_WDATA,
  output logic [AW-1:0] DL_RADDR,
  output logic [AW-1:0] COEF_ADDR,
  output logic          MAC_CLR,
  output logic          MAC_EN,
  output logic          Y_VALID,
  output logic          SEQ_WRAP,
  output logic [7:0]    SAMPLE_IDX,
  output logic          OVERRUN,
  output logic          BUSY
`ifdef FIR_SEQ_OVR_CNT_EN
  ,
  output logic [7:0]    OVR_CNT
`endif
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int KW = ($clog2(MAC_LAT + 1) > AW) ? $clog2(MAC_LAT + 1) : AW;
  localparam logic [TW-1:0] TIMER_MAX  = TW'(SAMPLE_DIV - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(N_TAPS - 1);
  localparam logic [KW-1:0] FLUSH_LAST = KW'(MAC_LAT - 1);
  localparam logic [7:0]    IDX_LAST   = 8'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_WRITE, S_MAC, S_FLUSH, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [KW-1:0] k_q, k_d;
  logic [7:0]    idx_q, idx_d;
  logic [DW-1:0] x_q, x_d;
  logic [AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d, coef_q, coef_d;
  logic [7:0]    sidx_q, sidx_d;
  logic          ldx_q, ldx_d, we_q, we_d, clr_q, clr_d, mac_en_q, mac_en_d;
  logic          yv_q, yv_d, wrap_q, wrap_d;
  logic          tick, drop, enter_done;

  assign tick = EN && (timer_q == TIMER_MAX);
  assign drop = tick && (state_q != S_IDLE);

`ifdef FIR_SEQ_OVR_CNT_EN
  logic [7:0] ovr_q, ovr_d;
  always_comb ovr_d = (drop && (ovr_q != 8'hFF)) ? ovr_q + 8'd1 : ovr_q;
  assign OVERRUN = (ovr_q != 8'd0);
  assign OVR_CNT = ovr_q;
`else
  logic ovr_q, ovr_d;
  always_comb ovr_d = ovr_q | drop;
  assign OVERRUN = ovr_q;
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    timer_d    = EN ? ((timer_q == TIMER_MAX) ? '0 : timer_q + TW'(1)) : '0;
    wptr_d     = wptr_q;
    k_d        = k_q;
    idx_d      = idx_q;
    x_d        = x_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    coef_d     = coef_q;
    sidx_d     = sidx_q;
    ldx_d      = 1'b0;
    we_d       = 1'b0;
    clr_d      = 1'b0;
    mac_en_d   = 1'b0;
    yv_d       = 1'b0;
    wrap_d     = 1'b0;
    enter_done = 1'b0;

    // Strobes are registered, so each is raised on the edge that enters its state.
    case (state_q)
      S_IDLE: if (tick) begin
        state_d = S_FETCH;
        ldx_d   = 1'b1;
      end
      S_FETCH: state_d = S_CAPT;
      S_CAPT: begin
        x_d     = X_IN;
        state_d = S_WRITE;
        we_d    = 1'b1;
        waddr_d = wptr_q;
      end
      S_WRITE: begin
        state_d  = S_MAC;
        k_d      = '0;
        mac_en_d = 1'b1;
        clr_d    = 1'b1;
        raddr_d  = wptr_q;
        coef_d   = '0;
      end
      S_MAC: if (k_q == K_LAST) begin
        k_d = '0;
        if (MAC_LAT == 0) enter_done = 1'b1;
        else              state_d    = S_FLUSH;
      end else begin
        k_d      = k_q + KW'(1);
        mac_en_d = 1'b1;
        raddr_d  = raddr_q - AW'(1);
        coef_d   = coef_q + AW'(1);
      end
      S_FLUSH: if (k_q == FLUSH_LAST) enter_done = 1'b1;
               else                   k_d        = k_q + KW'(1);
      S_DONE: begin
        wptr_d  = wptr_q + AW'(1);
        idx_d   = (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_done) begin
      state_d = S_DONE;
      yv_d    = 1'b1;
      wrap_d  = (idx_q == IDX_LAST);
      sidx_d  = idx_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      wptr_q   <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      coef_q   <= '0;
      sidx_q   <= '0;
      ldx_q    <= 1'b0;
      we_q     <= 1'b0;
      clr_q    <= 1'b0;
      mac_en_q <= 1'b0;
      yv_q     <= 1'b0;
      wrap_q   <= 1'b0;
      ovr_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of its peers.
      state_q  <= state_d;
      timer_q  <= timer_d;
      wptr_q   <= wptr_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      coef_q   <= coef_d;
      sidx_q   <= sidx_d;
      ldx_q    <= ldx_d;
      we_q     <= we_d;
      clr_q    <= clr_d;
      mac_en_q <= mac_en_d;
      yv_q     <= yv_d;
      wrap_q   <= wrap_d;
      ovr_q    <= ovr_d;
    end
  end

  assign LDX        = ldx_q;
  assign DL_WE      = we_q;
  assign DL_WADDR   = waddr_q;
  assign DL_WDATA   = x_q;
  assign DL_RADDR   = raddr_q;
  assign COEF_ADDR  = coef_q;
  assign MAC_CLR    = clr_q;
  assign MAC_EN     = mac_en_q;
  assign Y_VALID    = yv_q;
  assign SEQ_WRAP   = wrap_q;
  assign SAMPLE_IDX = sidx_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: random ROM data, event recorder, and a per-sample timing model.
// Covers reset, 201-sample run with wrap, EN drop, mid-MAC reset, and overrun on a short-period instance.
module tb_fir_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  f;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, en, en2;
  logic [15:0] x_in;
  logic        ldx, dl_we, mac_clr, mac_en, y_valid, seq_wrap, overrun, busy;
  logic [3:0]  dl_waddr, dl_raddr, coef_addr;
  logic [15:0] dl_wdata;
  logic [7:0]  sample_idx;
  logic        ldx2, dl_we2, mac_clr2, mac_en2, y_valid2, seq_wrap2, overrun2, busy2;
  logic [3:0]  dl_waddr2, dl_raddr2, coef_addr2;
  logic [15:0] dl_wdata2;
  logic [7:0]  sample_idx2;
`ifdef FIR_SEQ_OVR_CNT_EN
  logic [7:0]  ovr_cnt, ovr_cnt2;
`endif

  int unsigned cyc = 0;
  int          n_total = 0, n_pass = 0, n_fail = 0;
  int          ldx_total = 0, busy_cnt = 0;
  logic        hold;
  int unsigned ldx_q[$];
  logic [15:0] xd_q[$];
  rec_t        we_q[$], mac_q[$], yv_q[$];
  logic [43:0] outs;

  assign outs = {ldx, dl_we, dl_waddr, dl_wdata, dl_raddr, coef_addr,
                 mac_clr, mac_en, y_valid, seq_wrap, sample_idx, overrun, busy};

  fir_sequencer u_dut (
    .CLK(clk), .RST(rst), .EN(en), .LDX(ldx), .X_IN(x_in),
    .DL_WE(dl_we), .DL_WADDR(dl_waddr), .DL_WDATA(dl_wdata), .DL_RADDR(dl_raddr),
    .COEF_ADDR(coef_addr), .MAC_CLR(mac_clr), .MAC_EN(mac_en), .Y_VALID(y_valid),
    .SEQ_WRAP(seq_wrap), .SAMPLE_IDX(sample_idx), .OVERRUN(overrun), .BUSY(busy)
`ifdef FIR_SEQ_OVR_CNT_EN
    , .OVR_CNT(ovr_cnt)
`endif
  );

  fir_sequencer #(.N_TAPS(16), .SAMPLE_DIV(10)) u_ovr (
    .CLK(clk), .RST(rst), .EN(en2), .LDX(ldx2), .X_IN(x_in),
    .DL_WE(dl_we2), .DL_WADDR(dl_waddr2), .DL_WDATA(dl_wdata2), .DL_RADDR(dl_raddr2),
    .COEF_ADDR(coef_addr2), .MAC_CLR(mac_clr2), .MAC_EN(mac_en2), .Y_VALID(y_valid2),
    .SEQ_WRAP(seq_wrap2), .SAMPLE_IDX(sample_idx2), .OVERRUN(overrun2), .BUSY(busy2)
`ifdef FIR_SEQ_OVR_CNT_EN
    , .OVR_CNT(ovr_cnt2)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(input logic [31:0] c, input logic [15:0] a,
                              input logic [15:0] b, input logic [1:0] f);
    rec_t r;
    r.cyc = c; r.a = a; r.b = b; r.f = f;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Event recorder plus sample ROM: data is presented after each LDX and held through the capture edge.
  initial begin
    hold = 1'b0;
    x_in = '0;
    forever begin
      @(negedge clk);
      if (ldx === 1'b1) begin ldx_q.push_back(cyc); ldx_total++; end
      if (dl_we === 1'b1) we_q.push_back(mk(cyc, 16'(dl_waddr), dl_wdata, 2'b00));
      if (mac_en === 1'b1 || mac_clr === 1'b1)
        mac_q.push_back(mk(cyc, 16'(dl_raddr), 16'(coef_addr), {mac_clr, mac_en}));
      if (y_valid === 1'b1 || seq_wrap === 1'b1)
        yv_q.push_back(mk(cyc, 16'(sample_idx), 16'd0, {seq_wrap, y_valid}));
      if (busy === 1'b1) busy_cnt++;
      if (ldx === 1'b1) begin
        x_in = 16'($urandom);
        xd_q.push_back(x_in);
        hold = 1'b1;
      end else if (hold) hold = 1'b0;
      else x_in = 16'($urandom);
    end
  end

  // Expected events for one sample whose tick is at cycle t, n samples after reset.
  task automatic expect_sample(input int t, input int n, input int taps);
    logic [15:0] d;
    rec_t r;
    int wp;
    wp = n % 16;
    d  = '0;
    check($sformatf("ldx_present[%0d]", n), ldx_q.size() != 0, 1);
    if (ldx_q.size() != 0) check($sformatf("ldx_cycle[%0d]", n), ldx_q.pop_front(), t + 1);
    if (xd_q.size() != 0) d = xd_q.pop_front();
    check($sformatf("write_present[%0d]", n), we_q.size() != 0, 1);
    if (we_q.size() != 0) begin
      r = we_q.pop_front();
      check($sformatf("dl_write[%0d]", n), r, mk(t + 3, 16'(wp), d, 2'b00));
    end
    for (int k = 0; k < taps; k++) begin
      check($sformatf("mac_present[%0d.%0d]", n, k), mac_q.size() != 0, 1);
      if (mac_q.size() != 0) begin
        r = mac_q.pop_front();
        check($sformatf("mac_tap[%0d.%0d]", n, k), r,
              mk(t + 4 + k, 16'((wp + 16 - k) % 16), 16'(k), {k == 0, 1'b1}));
      end
    end
    if (taps == 16) begin
      check($sformatf("yvalid_present[%0d]", n), yv_q.size() != 0, 1);
      if (yv_q.size() != 0) begin
        r = yv_q.pop_front();
        check($sformatf("yvalid[%0d]", n), r,
              mk(t + 22, 16'(n % 200), 16'd0, {(n % 200) == 199, 1'b1}));
      end
    end
  endtask

  task automatic check_drained(input string tag);
    check(tag, ldx_q.size() + we_q.size() + mac_q.size() + yv_q.size() + xd_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, t, cnt;
    int drops[$];
    int cps[5];
    int ta;
    bit have;

    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 0);
    check("reset_ovr_inst", {ldx2, busy2, overrun2, sample_idx2}, 0);
`ifdef FIR_SEQ_OVR_CNT_EN
    check("reset_ovr_cnt", ovr_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 201 samples at the default rate: covers first-sample latency, wptr walk and index wrap.
    busy_cnt = 0;
    e  = int'(cyc);
    en = 1'b1;
    wait_until(e + 12895);
    en = 1'b0;
    wait_until(e + 12905);
    for (int n = 0; n <= 200; n++) expect_sample(e + 63 + 64 * n, n, 16);
    check_drained("run_no_extra_events");
    check("run_ldx_total", ldx_total, 201);
    check("run_busy_cycles", busy_cnt, 201 * 22);
    check("run_no_overrun", overrun, 0);

    // EN dropped during WRITE: sample completes, no new fetch.
    e  = int'(cyc);
    en = 1'b1;
    t  = e + 63;
    wait_until(t + 3);
    en = 1'b0;
    wait_until(t + 240);
    expect_sample(t, 201, 16);
    check_drained("en_low_no_ldx");

    // Timer must have been held at 0; then reset lands on the k=7 tap.
    e  = int'(cyc);
    en = 1'b1;
    t  = e + 63;
    wait_until(t + 11);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", outs, 0);
    rst = 1'b0;
    expect_sample(t, 202, 8);
    check_drained("abort_no_yvalid");
    wait_until(t + 12 + 63 + 30);
    expect_sample(t + 12 + 63, 0, 16);
    check_drained("after_abort_drained");
    en = 1'b0;
    @(negedge clk);

    // Short-period instance: busy for 22 cycles against a 10-cycle tick, so ticks get dropped.
    e   = int'(cyc);
    en2 = 1'b1;
    have = 1'b0;
    ta  = 0;
    for (int m = 0; m < 400; m++) begin
      int tk;
      tk = e + 9 + 10 * m;
      if (!have || tk > ta + 22) begin ta = tk; have = 1'b1; end
      else drops.push_back(tk);
    end
    cps = '{19, 20, 45, 300, 3995};
    for (int i = 0; i < 5; i++) begin
      wait_until(e + cps[i]);
      cnt = 0;
      foreach (drops[j]) if (drops[j] < e + cps[i]) cnt++;
      check($sformatf("overrun@%0d", cps[i]), overrun2, cnt != 0);
`ifdef FIR_SEQ_OVR_CNT_EN
      check($sformatf("ovr_cnt@%0d", cps[i]), ovr_cnt2, (cnt > 255) ? 255 : cnt);
`endif
    end
    en2 = 1'b0;
    check("main_overrun_still_clear", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
